// File: rtl/parking_gate_controller.sv
// rtl/parking_gate_controller.sv - PIN-gated parking barrier FSM with wrong-PIN and tailgating alarms
// Optional AUTHORIZED dwell timeout enabled by defining AUTH_TIMEOUT_EN.
module parking_gate_controller #(
    parameter logic [7:0] PSSWRD         = 8'b0101_0111,
    parameter int         MAX_ATTEMPTS   = 3,
    parameter int         TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sensor_1,
    input  logic       sensor_2,
    input  logic [7:0] psswrd_atmpt,
    input  logic       try_psswrd,
    output logic       open_gate,
    output logic       close_gate,
    output logic       alarm_1,
    output logic       alarm_2
);

    localparam logic [1:0] WAIT_CAR   = 2'd0;
    localparam logic [1:0] ENTER_PIN  = 2'd1;
    localparam logic [1:0] AUTHORIZED = 2'd2;
    localparam logic [1:0] BLOCKED    = 2'd3;
    localparam logic [1:0] MAX_CNT    = 2'(MAX_ATTEMPTS);

    logic [1:0] state_q, state_d;
    logic [1:0] fail_q, fail_d;
    logic       alarm_1_q, alarm_1_d;
    logic       try_q;
    logic       open_q, close_q, alarm_2_q;
    logic       attempt, pw_ok;

`ifdef AUTH_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0] timer_q, timer_d;
    logic          timeout;

    assign timeout = (timer_q == TW'(TIMEOUT_CYCLES - 1));
`endif

    // A held strobe is one attempt: only the low-to-high transition counts.
    assign attempt = try_psswrd & ~try_q;
    assign pw_ok   = (psswrd_atmpt == PSSWRD);

    always_comb begin
        state_d   = state_q;
        fail_d    = fail_q;
        alarm_1_d = alarm_1_q;
        if (sensor_1 && sensor_2) begin
            state_d = BLOCKED;
        end else begin
            case (state_q)
                WAIT_CAR: begin
                    if (sensor_1) state_d = ENTER_PIN;
                end
                ENTER_PIN: begin
                    if (attempt && pw_ok) begin
                        state_d   = AUTHORIZED;
                        fail_d    = 2'd0;
                        alarm_1_d = 1'b0;
                    end else if (attempt && (fail_q < MAX_CNT)) begin
                        fail_d = fail_q + 2'd1;
                        if (fail_q + 2'd1 == MAX_CNT) alarm_1_d = 1'b1;
                    end
                end
                AUTHORIZED: begin
                    if (sensor_2 && !sensor_1) state_d = WAIT_CAR;
`ifdef AUTH_TIMEOUT_EN
                    else if (timeout) state_d = WAIT_CAR;
`endif
                end
                default: begin
                    if (attempt && pw_ok) begin
                        state_d   = WAIT_CAR;
                        fail_d    = 2'd0;
                        alarm_1_d = 1'b0;
                    end
                end
            endcase
        end
    end

`ifdef AUTH_TIMEOUT_EN
    // Counts edges spent in AUTHORIZED; any exit clears it.
    always_comb begin
        timer_d = '0;
        if (state_q == AUTHORIZED && state_d == AUTHORIZED) timer_d = timer_q + TW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) timer_q <= '0;
        else     timer_q <= timer_d;
    end
`endif

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= WAIT_CAR;
            fail_q    <= 2'd0;
            alarm_1_q <= 1'b0;
            try_q     <= 1'b0;
            open_q    <= 1'b0;
            close_q   <= 1'b1;
            alarm_2_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            fail_q    <= fail_d;
            alarm_1_q <= alarm_1_d;
            try_q     <= try_psswrd;
            open_q    <= (state_d == AUTHORIZED);
            close_q   <= (state_d != AUTHORIZED);
            alarm_2_q <= (state_d == BLOCKED);
        end
    end

    assign open_gate  = open_q;
    assign close_gate = close_q;
    assign alarm_1    = alarm_1_q;
    assign alarm_2    = alarm_2_q;

endmodule
